r5p_degu_tcb_arb: RTL and testbench

- Two-manager to one-subordinate TCB arbiter placed directly downstream of the Degu core.
- Merges the core's instruction-fetch port (IFU) and load/store port (LSU) onto a single memory bus, for single-ported SRAM or a shared system bus.
- Grants one request per cycle, holds the grant while a request is stalled, and routes each response back to the issuing manager after the fixed bus read latency.

---
 rtl/r5p_degu_tcb_arb.sv | 191 +++++++++++++++++++
 tb/tb_r5p_degu_tcb_arb.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/r5p_degu_tcb_arb.sv
// Two-manager (IFU, LSU) to one-subordinate TCB arbiter for the Degu core.
// Define R5P_DEGU_ARB_RR_EN for round-robin arbitration; default is fixed LSU-over-IFU priority.
module r5p_degu_tcb_arb #(
   parameter int AW  = 32,
   parameter int DW  = 32,
   parameter int BW  = DW/8,
   parameter int DLY = 1
) (
   input  logic          clk,
   input  logic          rst,
   // IFU manager
   input  logic          ifu_vld,
   input  logic          ifu_wen,
   input  logic [AW-1:0] ifu_adr,
   input  logic [BW-1:0] ifu_ben,
   input  logic [DW-1:0] ifu_wdt,
   output logic          ifu_rdy,
   output logic [DW-1:0] ifu_rdt,
   output logic          ifu_err,
   // LSU manager
   input  logic          lsu_vld,
   input  logic          lsu_wen,
   input  logic [AW-1:0] lsu_adr,
   input  logic [BW-1:0] lsu_ben,
   input  logic [DW-1:0] lsu_wdt,
   output logic          lsu_rdy,
   output logic [DW-1:0] lsu_rdt,
   output logic          lsu_err,
   // memory subordinate
   output logic          mem_vld,
   output logic          mem_wen,
   output logic [AW-1:0] mem_adr,
   output logic [BW-1:0] mem_ben,
   output logic [DW-1:0] mem_wdt,
   input  logic          mem_rdy,
   input  logic [DW-1:0] mem_rdt,
   input  logic          mem_err
);

   typedef enum logic {
      ID_IFU = 1'b0,
      ID_LSU = 1'b1
   } mgr_e;

   mgr_e gnt_s;
   logic gnt_vld_s;
   logic trn_s;
   logic lck_ena_q, lck_ena_d;
   mgr_e lck_id_q,  lck_id_d;
   logic own_vld_s;
   mgr_e own_id_s;

`ifdef R5P_DEGU_ARB_RR_EN
   mgr_e lst_q, lst_d;
`endif

   // grant selection: a stalled request keeps the bus until it completes
   always_comb begin
      gnt_s = ID_IFU;
      if (lck_ena_q) begin
         gnt_s = lck_id_q;
      end
`ifdef R5P_DEGU_ARB_RR_EN
      else if (ifu_vld && lsu_vld) begin
         gnt_s = (lst_q == ID_IFU) ? ID_LSU : ID_IFU;
      end
`endif
      else if (lsu_vld) begin
         gnt_s = ID_LSU;
      end else begin
         gnt_s = ID_IFU;
      end
   end

   assign gnt_vld_s = lck_ena_q | ifu_vld | lsu_vld;

   // request multiplexer from the granted manager
   always_comb begin
      mem_vld = ifu_vld;
      mem_wen = ifu_wen;
      mem_adr = ifu_adr;
      mem_ben = ifu_ben;
      mem_wdt = ifu_wdt;
      if (gnt_s == ID_LSU) begin
         mem_vld = lsu_vld;
         mem_wen = lsu_wen;
         mem_adr = lsu_adr;
         mem_ben = lsu_ben;
         mem_wdt = lsu_wdt;
      end else begin
         mem_vld = ifu_vld;
         mem_wen = ifu_wen;
         mem_adr = ifu_adr;
         mem_ben = ifu_ben;
         mem_wdt = ifu_wdt;
      end
   end

   assign ifu_rdy = mem_rdy & gnt_vld_s & (gnt_s == ID_IFU);
   assign lsu_rdy = mem_rdy & gnt_vld_s & (gnt_s == ID_LSU);
   assign trn_s   = mem_vld & mem_rdy;

   // lock next state: capture a stalled manager, release on its transfer
   always_comb begin
      lck_ena_d = lck_ena_q;
      lck_id_d  = lck_id_q;
      if (trn_s) begin
         lck_ena_d = 1'b0;
      end else if (mem_vld) begin
         lck_ena_d = 1'b1;
         lck_id_d  = gnt_s;
      end else begin
         lck_ena_d = lck_ena_q;
         lck_id_d  = lck_id_q;
      end
   end

   // lock register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lck_ena_q <= 1'b0;
         lck_id_q  <= ID_IFU;
      end else begin
         lck_ena_q <= lck_ena_d;
         lck_id_q  <= lck_id_d;
      end
   end

`ifdef R5P_DEGU_ARB_RR_EN
   // last-grant next state, only completed transfers count
   always_comb begin
      lst_d = lst_q;
      if (trn_s) begin
         lst_d = gnt_s;
      end else begin
         lst_d = lst_q;
      end
   end

   // last-grant register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lst_q <= ID_IFU;
      end else begin
         lst_q <= lst_d;
      end
   end
`endif

   generate
      if (DLY == 0) begin : g_dly0
         assign own_vld_s = trn_s;
         assign own_id_s  = gnt_s;
      end else begin : g_dly
         logic [DLY-1:0] pvl_q, pvl_d;
         logic [DLY-1:0] pid_q, pid_d;

         // response ownership shift, stage 0 loaded from the current transfer
         always_comb begin
            pvl_d    = pvl_q;
            pid_d    = pid_q;
            pvl_d[0] = trn_s;
            pid_d[0] = gnt_s;
            for (int i = 1; i < DLY; i++) begin
               pvl_d[i] = pvl_q[i-1];
               pid_d[i] = pid_q[i-1];
            end
         end

         // response ownership pipeline registers
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               pvl_q <= '0;
               pid_q <= '0;
            end else begin
               pvl_q <= pvl_d;
               pid_q <= pid_d;
            end
         end

         assign own_vld_s = pvl_q[DLY-1];
         assign own_id_s  = mgr_e'(pid_q[DLY-1]);
      end
   endgenerate

   assign ifu_rdt = mem_rdt;
   assign lsu_rdt = mem_rdt;
   assign ifu_err = mem_err & own_vld_s & (own_id_s == ID_IFU);
   assign lsu_err = mem_err & own_vld_s & (own_id_s == ID_LSU);

endmodule

// File: tb/tb_r5p_degu_tcb_arb.sv
// Bench for r5p_degu_tcb_arb: three instances (DLY=0,1,2) share stimulus and are
// checked every cycle against a transaction-level model plus directed literal checks.
module tb_r5p_degu_tcb_arb;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ifu_vld = 1'b0, ifu_wen = 1'b0, lsu_vld = 1'b0, lsu_wen = 1'b0;
   logic [31:0] ifu_adr = 32'h0, ifu_wdt = 32'h0, lsu_adr = 32'h0, lsu_wdt = 32'h0;
   logic [3:0]  ifu_ben = 4'hF, lsu_ben = 4'hF;
   logic        mem_rdy = 1'b0, mem_err = 1'b0;
   logic [31:0] mem_rdt = 32'h0;

   logic        ifu_rdy_w [3], ifu_err_w [3], lsu_rdy_w [3], lsu_err_w [3];
   logic        mem_vld_w [3], mem_wen_w [3];
   logic [31:0] ifu_rdt_w [3], lsu_rdt_w [3], mem_adr_w [3], mem_wdt_w [3];
   logic [3:0]  mem_ben_w [3];

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   genvar g;
   generate
      for (g = 0; g < 3; g++) begin : g_dut
         r5p_degu_tcb_arb #(.AW(32), .DW(32), .BW(4), .DLY(g)) dut (
            .clk     (clk),
            .rst     (rst),
            .ifu_vld (ifu_vld),
            .ifu_wen (ifu_wen),
            .ifu_adr (ifu_adr),
            .ifu_ben (ifu_ben),
            .ifu_wdt (ifu_wdt),
            .ifu_rdy (ifu_rdy_w[g]),
            .ifu_rdt (ifu_rdt_w[g]),
            .ifu_err (ifu_err_w[g]),
            .lsu_vld (lsu_vld),
            .lsu_wen (lsu_wen),
            .lsu_adr (lsu_adr),
            .lsu_ben (lsu_ben),
            .lsu_wdt (lsu_wdt),
            .lsu_rdy (lsu_rdy_w[g]),
            .lsu_rdt (lsu_rdt_w[g]),
            .lsu_err (lsu_err_w[g]),
            .mem_vld (mem_vld_w[g]),
            .mem_wen (mem_wen_w[g]),
            .mem_adr (mem_adr_w[g]),
            .mem_ben (mem_ben_w[g]),
            .mem_wdt (mem_wdt_w[g]),
            .mem_rdy (mem_rdy),
            .mem_rdt (mem_rdt),
            .mem_err (mem_err)
         );
      end
   endgenerate

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: manager 0 = IFU, 1 = LSU. History of (transfer, owner) per cycle, newest last.
   int m_lck = 0, m_who = 0, m_last = 0;
   int hv [$];
   int hw [$];

   initial forever begin
      int gm, any, xv, xfer, ov, ow;
      logic        xw;
      logic [31:0] xa, xd;
      logic [3:0]  xb;
      @(negedge clk);
      if (rst) begin
         m_lck = 0; m_last = 0;
         hv.delete(); hw.delete();
      end
      any = (m_lck != 0 || ifu_vld || lsu_vld) ? 1 : 0;
      if (m_lck != 0)             gm = m_who;
`ifdef R5P_DEGU_ARB_RR_EN
      else if (ifu_vld && lsu_vld) gm = 1 - m_last;
`endif
      else                         gm = lsu_vld ? 1 : 0;
      xv = gm ? int'(lsu_vld) : int'(ifu_vld);
      xw = gm ? lsu_wen : ifu_wen;
      xa = gm ? lsu_adr : ifu_adr;
      xb = gm ? lsu_ben : ifu_ben;
      xd = gm ? lsu_wdt : ifu_wdt;
      xfer = (xv != 0 && mem_rdy) ? 1 : 0;
      for (int k = 0; k < 3; k++) begin
         if (k == 0) begin
            ov = xfer; ow = gm;
         end else if (hv.size() >= k) begin
            ov = hv[hv.size()-k]; ow = hw[hw.size()-k];
         end else begin
            ov = 0; ow = 0;
         end
         chk($sformatf("d%0d_mem_vld", k), 64'(mem_vld_w[k]), 64'(xv));
         if (xv != 0) begin
            chk($sformatf("d%0d_mem_wen", k), 64'(mem_wen_w[k]), 64'(xw));
            chk($sformatf("d%0d_mem_adr", k), 64'(mem_adr_w[k]), 64'(xa));
            chk($sformatf("d%0d_mem_ben", k), 64'(mem_ben_w[k]), 64'(xb));
            chk($sformatf("d%0d_mem_wdt", k), 64'(mem_wdt_w[k]), 64'(xd));
         end
         chk($sformatf("d%0d_ifu_rdy", k), 64'(ifu_rdy_w[k]), 64'(any != 0 && gm == 0 && mem_rdy));
         chk($sformatf("d%0d_lsu_rdy", k), 64'(lsu_rdy_w[k]), 64'(any != 0 && gm == 1 && mem_rdy));
         chk($sformatf("d%0d_ifu_rdt", k), 64'(ifu_rdt_w[k]), 64'(mem_rdt));
         chk($sformatf("d%0d_lsu_rdt", k), 64'(lsu_rdt_w[k]), 64'(mem_rdt));
         chk($sformatf("d%0d_ifu_err", k), 64'(ifu_err_w[k]), 64'(mem_err && ov != 0 && ow == 0));
         chk($sformatf("d%0d_lsu_err", k), 64'(lsu_err_w[k]), 64'(mem_err && ov != 0 && ow == 1));
      end
      if (!rst) begin
         hv.push_back(xfer);
         hw.push_back(gm);
         if (hv.size() > 8) begin
            void'(hv.pop_front());
            void'(hw.pop_front());
         end
         if (xfer != 0) begin
            m_lck = 0; m_last = gm;
         end else if (xv != 0) begin
            m_lck = 1; m_who = gm;
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
      mem_rdt = mem_rdt + 32'h01010101;
   endtask

   logic [31:0] rr_adr [4];

   initial begin
`ifdef R5P_DEGU_ARB_RR_EN
      rr_adr[0] = 32'hB000; rr_adr[1] = 32'h0500; rr_adr[2] = 32'hB000; rr_adr[3] = 32'h0500;
`else
      rr_adr[0] = 32'hB000; rr_adr[1] = 32'hB000; rr_adr[2] = 32'hB000; rr_adr[3] = 32'hB000;
`endif
      // reset: errors low, combinational path follows inputs
      #2;
      chk("rst_ifu_err", 64'(ifu_err_w[1]), 64'h0);
      chk("rst_lsu_err", 64'(lsu_err_w[2]), 64'h0);
      ifu_vld = 1'b1; ifu_adr = 32'h0700;
      #1;
      chk("rst_mem_vld_follow", 64'(mem_vld_w[1]), 64'h1);
      cyc(); cyc();
      rst = 1'b0; ifu_vld = 1'b0;

      // IFU streaming reads, DLY=1
      cyc(); ifu_vld = 1'b1; ifu_adr = 32'h0100; mem_rdy = 1'b1; #1;
      chk("t1_ifu_rdy", 64'(ifu_rdy_w[1]), 64'h1);
      chk("t1_mem_adr", 64'(mem_adr_w[1]), 64'h100);
      cyc(); mem_rdt = 32'h11111111; #1;
      chk("t1_ifu_rdy2", 64'(ifu_rdy_w[1]), 64'h1);
      chk("t1_ifu_rdt", 64'(ifu_rdt_w[1]), 64'h11111111);
      chk("t1_ifu_err", 64'(ifu_err_w[1]), 64'h0);
      cyc();

      // simultaneous requests: LSU write wins, IFU next cycle
      cyc(); ifu_adr = 32'h0200; lsu_vld = 1'b1; lsu_wen = 1'b1; lsu_adr = 32'h8000; lsu_wdt = 32'hDEADBEEF; #1;
      chk("t2_mem_adr", 64'(mem_adr_w[1]), 64'h8000);
      chk("t2_mem_wen", 64'(mem_wen_w[1]), 64'h1);
      chk("t2_mem_wdt", 64'(mem_wdt_w[1]), 64'hDEADBEEF);
      chk("t2_lsu_rdy", 64'(lsu_rdy_w[1]), 64'h1);
      chk("t2_ifu_rdy", 64'(ifu_rdy_w[1]), 64'h0);
      cyc(); lsu_vld = 1'b0; lsu_wen = 1'b0; #1;
      chk("t2_ifu_adr", 64'(mem_adr_w[1]), 64'h200);
      chk("t2_ifu_rdy2", 64'(ifu_rdy_w[1]), 64'h1);
      cyc(); ifu_vld = 1'b0;

      // IFU stalled 3 cycles, LSU arrives during the stall and must wait
      cyc(); ifu_vld = 1'b1; ifu_adr = 32'h0300; mem_rdy = 1'b0; #1;
      chk("t3_mem_vld", 64'(mem_vld_w[1]), 64'h1);
      chk("t3_ifu_rdy", 64'(ifu_rdy_w[1]), 64'h0);
      cyc(); lsu_vld = 1'b1; lsu_adr = 32'h9000; #1;
      chk("t3_hold_adr2", 64'(mem_adr_w[1]), 64'h300);
      chk("t3_lsu_rdy2", 64'(lsu_rdy_w[1]), 64'h0);
      cyc(); #1;
      chk("t3_hold_adr3", 64'(mem_adr_w[0]), 64'h300);
      cyc(); mem_rdy = 1'b1; #1;
      chk("t3_rel_adr", 64'(mem_adr_w[1]), 64'h300);
      chk("t3_rel_ifu_rdy", 64'(ifu_rdy_w[1]), 64'h1);
      chk("t3_rel_lsu_rdy", 64'(lsu_rdy_w[1]), 64'h0);
      cyc(); ifu_vld = 1'b0; #1;
      chk("t3_lsu_adr", 64'(mem_adr_w[1]), 64'h9000);
      chk("t3_lsu_rdy", 64'(lsu_rdy_w[1]), 64'h1);
      cyc(); lsu_vld = 1'b0;

      // DLY=2 error routing: LSU read, IFU read, error on first response only
      cyc(); lsu_vld = 1'b1; lsu_adr = 32'hA000;
      cyc(); lsu_vld = 1'b0; ifu_vld = 1'b1; ifu_adr = 32'h0400;
      cyc(); ifu_vld = 1'b0; mem_err = 1'b1; #1;
      chk("t4_lsu_err_d2", 64'(lsu_err_w[2]), 64'h1);
      chk("t4_ifu_err_d2", 64'(ifu_err_w[2]), 64'h0);
      chk("t4_ifu_err_d1", 64'(ifu_err_w[1]), 64'h1);
      cyc(); mem_err = 1'b0; #1;
      chk("t4_ifu_err_d2_next", 64'(ifu_err_w[2]), 64'h0);
      chk("t4_lsu_err_d2_next", 64'(lsu_err_w[2]), 64'h0);

      // both valid for four cycles
      for (int i = 0; i < 4; i++) begin
         cyc(); ifu_vld = 1'b1; ifu_adr = 32'h0500; lsu_vld = 1'b1; lsu_adr = 32'hB000; #1;
         chk($sformatf("t5_gnt_adr%0d", i), 64'(mem_adr_w[0]), 64'(rr_adr[i]));
      end
      cyc(); ifu_vld = 1'b0; lsu_vld = 1'b0;

      // reset during an in-flight DLY=2 read with mem_err asserted
      cyc(); lsu_vld = 1'b1; lsu_adr = 32'hC000;
      cyc(); lsu_vld = 1'b0; rst = 1'b1; mem_err = 1'b1; #1;
      chk("t6_rst_lsu_err_d2", 64'(lsu_err_w[2]), 64'h0);
      chk("t6_rst_lsu_err_d1", 64'(lsu_err_w[1]), 64'h0);
      cyc(); rst = 1'b0; ifu_vld = 1'b1; ifu_adr = 32'h0600; #1;
      chk("t6_mem_vld", 64'(mem_vld_w[2]), 64'h1);
      chk("t6_ifu_rdy", 64'(ifu_rdy_w[2]), 64'h1);
      chk("t6_lsu_err_d2", 64'(lsu_err_w[2]), 64'h0);
      chk("t6_ifu_err_d2", 64'(ifu_err_w[2]), 64'h0);
      cyc(); ifu_vld = 1'b0; #1;
      chk("t6_ifu_err_d1", 64'(ifu_err_w[1]), 64'h1);
      chk("t6_lsu_err_d2b", 64'(lsu_err_w[2]), 64'h0);
      cyc(); #1;
      chk("t6_ifu_err_d2b", 64'(ifu_err_w[2]), 64'h1);
      cyc(); mem_err = 1'b0;
      cyc(); cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
